// File: rtl/i2c_slave_pkg.sv
// Shared types for the I2C register-file slave: FSM state encoding and ACK/NACK line levels.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package i2c_slave_pkg;

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        REG,
        REG_ACK,
        WDATA,
        WDATA_ACK,
        RDATA,
        RDATA_ACK
    } i2c_state_t;

    // SDA drive levels during the ninth (acknowledge) bit
    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;

endpackage

// File: rtl/i2c_line_sync.sv
// SCL/SDA synchroniser with optional glitch filter (I2C_GLITCH_FILTER_EN) and bus-condition edge detect.
// Latency: SYNC_STG CLK from pin to s_scl/s_sda (+2 CLK with the filter); edge strobes are combinational on top.
// Backpressure: none; free-running, edge strobes are single-cycle pulses.
module i2c_line_sync #(
    parameter int SYNC_STG = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic scl,
    input  logic sda,
    output logic s_scl,
    output logic s_sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    logic [SYNC_STG-1:0] scl_sync;
    logic [SYNC_STG-1:0] sda_sync;
    logic                scl_raw;
    logic                sda_raw;
    logic                scl_prev;
    logic                sda_prev;

    // Metastability chains; an idle bus sits high so the chains reset to 1
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_sync <= '1;
            sda_sync <= '1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STG-2:0], scl};
            sda_sync <= {sda_sync[SYNC_STG-2:0], sda};
        end
    end

    assign scl_raw = scl_sync[SYNC_STG-1];
    assign sda_raw = sda_sync[SYNC_STG-1];

`ifdef I2C_GLITCH_FILTER_EN
    logic [1:0] scl_hist;
    logic [1:0] sda_hist;
    logic       scl_filt;
    logic       sda_filt;

    // Two-deep sample history plus the held filtered level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_hist <= 2'b11;
            sda_hist <= 2'b11;
            scl_filt <= 1'b1;
            sda_filt <= 1'b1;
        end else begin
            scl_hist <= {scl_hist[0], scl_raw};
            sda_hist <= {sda_hist[0], sda_raw};
            scl_filt <= s_scl;
            sda_filt <= s_sda;
        end
    end

    // Follow the line only once three consecutive samples agree; otherwise hold
    always_comb begin
        s_scl = scl_filt;
        s_sda = sda_filt;
        if (scl_raw == scl_hist[0] && scl_hist[0] == scl_hist[1]) s_scl = scl_raw;
        if (sda_raw == sda_hist[0] && sda_hist[0] == sda_hist[1]) s_sda = sda_raw;
    end
`else
    assign s_scl = scl_raw;
    assign s_sda = sda_raw;
`endif

    // Previous clean levels for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_prev <= 1'b1;
            sda_prev <= 1'b1;
        end else begin
            scl_prev <= s_scl;
            sda_prev <= s_sda;
        end
    end

    assign scl_rise  =  s_scl & ~scl_prev;
    assign scl_fall  = ~s_scl &  scl_prev;
    // SDA may only move while SCL is high for START/STOP, so require SCL high on both samples
    assign start_det =  s_scl &  scl_prev &  sda_prev & ~s_sda;
    assign stop_det  =  s_scl &  scl_prev & ~sda_prev &  s_sda;

endmodule

// File: rtl/i2c_slave_regfile.sv
// I2C slave over a DEPTH x 8 register file with auto-increment, shared with an on-chip host port.
// Latency: ACK/read bits driven 1 CLK after the detected SCL fall; bus_wr fires with the regfile write; host read is combinational.
// Backpressure: none; the I2C master paces transfers, host writes are always taken (bus commit wins a same-index clash). Optional I2C_GLITCH_FILTER_EN.
module i2c_slave_regfile
    import i2c_slave_pkg::*;
#(
    parameter logic [6:0] DEV_ID   = 7'h05,
    parameter int         DEPTH    = 16,
    parameter int         SYNC_STG = 2,
    parameter logic [7:0] RST_VAL  = 8'h00,
    localparam int        AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          CLK,
    input  logic          Reset,
    input  logic          SCL,
    input  logic          iSDA,
    output logic          oSDA,
    input  logic [AW-1:0] host_addr,
    input  logic          host_we,
    input  logic [7:0]    host_wdata,
    output logic [7:0]    host_rdata,
    output logic          bus_wr,
    output logic [AW-1:0] bus_waddr,
    output logic          busy
);

    logic s_scl, s_sda, scl_rise, scl_fall, start_det, stop_det;

    i2c_state_t    state_q, state_d;
    logic [7:0]    shift_q, shift_d;
    logic [2:0]    cnt_q,   cnt_d;
    logic          full_q,  full_d;
    logic [AW-1:0] ptr_q,   ptr_d;
    logic          rw_q,    rw_d;
    logic          osda_q,  osda_d;
    logic          busy_q,  busy_d;
    logic          mack_q,  mack_d;
    logic          commit;
    logic [7:0]    regs [DEPTH];
    logic [7:0]    rd_cur;
    logic [7:0]    rd_nxt;

    i2c_line_sync #(.SYNC_STG(SYNC_STG)) u_sync (
        .clk       (CLK),
        .rst       (Reset),
        .scl       (SCL),
        .sda       (iSDA),
        .s_scl     (s_scl),
        .s_sda     (s_sda),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    // Register pointer advance, wrapping at the last register
    function automatic logic [AW-1:0] wrap_inc(input logic [AW-1:0] p);
        if (p == AW'(DEPTH - 1)) return '0;
        return p + 1'b1;
    endfunction

    assign rd_cur = regs[ptr_q];
    assign rd_nxt = regs[wrap_inc(ptr_q)];

    // FSM state and datapath registers; reset releases SDA immediately
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            full_q  <= 1'b0;
            ptr_q   <= '0;
            rw_q    <= 1'b0;
            osda_q  <= 1'b1;
            busy_q  <= 1'b0;
            mack_q  <= I2C_NACK;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            full_q  <= full_d;
            ptr_q   <= ptr_d;
            rw_q    <= rw_d;
            osda_q  <= osda_d;
            busy_q  <= busy_d;
            mack_q  <= mack_d;
        end
    end

    // Next-state logic: bus conditions override everything, bytes are acted on at the fall after bit 8
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        full_d  = full_q;
        ptr_d   = ptr_q;
        rw_d    = rw_q;
        osda_d  = osda_q;
        busy_d  = busy_q;
        mack_d  = mack_q;
        commit  = 1'b0;

        if (stop_det) begin
            state_d = IDLE;
            osda_d  = 1'b1;
            busy_d  = 1'b0;
            cnt_d   = '0;
            full_d  = 1'b0;
        end else if (start_det) begin
            // A partially shifted byte is simply dropped
            state_d = ADDR;
            osda_d  = 1'b1;
            cnt_d   = '0;
            full_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: ;

                ADDR, REG, WDATA: begin
                    if (scl_rise && !full_q) begin
                        shift_d = {shift_q[6:0], s_sda};
                        cnt_d   = cnt_q + 3'd1;
                        if (cnt_q == 3'd7) full_d = 1'b1;
                    end else if (scl_fall && full_q) begin
                        full_d = 1'b0;
                        if (state_q == ADDR) begin
                            if (shift_q[7:1] == DEV_ID) begin
                                state_d = ADDR_ACK;
                                osda_d  = I2C_ACK;
                                rw_d    = shift_q[0];
                                busy_d  = 1'b1;
                            end else begin
                                state_d = IDLE;
                                osda_d  = I2C_NACK;
                                busy_d  = 1'b0;
                            end
                        end else if (state_q == REG) begin
                            if ({1'b0, shift_q} < 9'(DEPTH)) begin
                                ptr_d   = shift_q[AW-1:0];
                                state_d = REG_ACK;
                                osda_d  = I2C_ACK;
                            end else begin
                                state_d = IDLE;
                                osda_d  = I2C_NACK;
                                busy_d  = 1'b0;
                            end
                        end else begin
                            commit  = 1'b1;
                            state_d = WDATA_ACK;
                            osda_d  = I2C_ACK;
                        end
                    end
                end

                ADDR_ACK: begin
                    if (scl_fall) begin
                        cnt_d  = '0;
                        full_d = 1'b0;
                        if (rw_q) begin
                            state_d = RDATA;
                            osda_d  = rd_cur[7];
                            shift_d = {rd_cur[6:0], 1'b1};
                        end else begin
                            state_d = REG;
                            osda_d  = 1'b1;
                        end
                    end
                end

                REG_ACK: begin
                    if (scl_fall) begin
                        state_d = WDATA;
                        osda_d  = 1'b1;
                    end
                end

                WDATA_ACK: begin
                    if (scl_fall) begin
                        state_d = WDATA;
                        osda_d  = 1'b1;
                        ptr_d   = wrap_inc(ptr_q);
                    end
                end

                RDATA: begin
                    if (scl_rise && !full_q) begin
                        cnt_d = cnt_q + 3'd1;
                        if (cnt_q == 3'd7) full_d = 1'b1;
                    end else if (scl_fall) begin
                        if (full_q) begin
                            full_d  = 1'b0;
                            state_d = RDATA_ACK;
                            osda_d  = 1'b1;
                        end else begin
                            osda_d  = shift_q[7];
                            shift_d = {shift_q[6:0], 1'b1};
                        end
                    end
                end

                RDATA_ACK: begin
                    if (scl_rise) begin
                        mack_d = s_sda;
                    end else if (scl_fall) begin
                        if (mack_q == I2C_ACK) begin
                            ptr_d   = wrap_inc(ptr_q);
                            state_d = RDATA;
                            osda_d  = rd_nxt[7];
                            shift_d = {rd_nxt[6:0], 1'b1};
                        end else begin
                            state_d = IDLE;
                            osda_d  = 1'b1;
                            busy_d  = 1'b0;
                        end
                    end
                end

                default: begin
                    state_d = IDLE;
                    osda_d  = 1'b1;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    // Register file: host writes land unless the bus commits to the same index this cycle
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= RST_VAL;
        end else begin
            if (host_we && !(commit && host_addr == ptr_q)) regs[host_addr] <= host_wdata;
            if (commit) regs[ptr_q] <= shift_q;
        end
    end

    assign oSDA       = osda_q;
    assign busy       = busy_q;
    assign bus_wr     = commit;
    assign bus_waddr  = ptr_q;
    assign host_rdata = regs[host_addr];

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Bench for i2c_slave_regfile: bit-banged I2C master, host-port stimulus, queue-based scoreboard.
// Latency: n/a.
// Backpressure: n/a.
module tb_i2c_slave_regfile;

    localparam int Q = 4;

    logic       CLK = 1'b0;
    logic       Reset = 1'b1;
    logic       scl = 1'b1;
    logic       sda_m = 1'b1;
    logic       isda;
    logic       osda;
    logic [3:0] host_addr = '0;
    logic       host_we = 1'b0;
    logic [7:0] host_wdata = '0;
    logic [7:0] host_rdata;
    logic       bus_wr;
    logic [3:0] bus_waddr;
    logic       busy;

    int    checks = 0;
    int    failures = 0;
    int    exp_waddr_q[$];
    string dchk_name_q[$];
    int    dchk_act_q[$];
    int    dchk_exp_q[$];

    logic coll_arm = 1'b0;
    logic coll_hit = 1'b0;
    logic busy_seen = 1'b0;
    logic low_seen = 1'b0;

    // Open-drain bus: either side can pull SDA low
    assign isda = sda_m & osda;

    always #5 CLK = ~CLK;

    i2c_slave_regfile dut (
        .CLK        (CLK),
        .Reset      (Reset),
        .SCL        (scl),
        .iSDA       (isda),
        .oSDA       (osda),
        .host_addr  (host_addr),
        .host_we    (host_we),
        .host_wdata (host_wdata),
        .host_rdata (host_rdata),
        .bus_wr     (bus_wr),
        .bus_waddr  (bus_waddr),
        .busy       (busy)
    );

    // Scoreboard monitor: pops expected commit indices on bus_wr and drains queued direct checks
    always @(negedge CLK) begin
        if (bus_wr) begin
            checks++;
            if (exp_waddr_q.size() == 0) begin
                failures++;
                $display("FAIL bus_wr_unexpected waddr=%0d required=none", bus_waddr);
            end else begin
                int e;
                e = exp_waddr_q.pop_front();
                if (int'(bus_waddr) != e) begin
                    failures++;
                    $display("FAIL bus_waddr actual=%0d required=%0d", bus_waddr, e);
                end
            end
        end
        while (dchk_name_q.size() > 0) begin
            string n;
            int a;
            int e;
            n = dchk_name_q.pop_front();
            a = dchk_act_q.pop_front();
            e = dchk_exp_q.pop_front();
            checks++;
            if (a != e) begin
                failures++;
                $display("FAIL %s actual=0x%0h required=0x%0h", n, a, e);
            end
        end
    end

    task automatic check(input string n, input int a, input int e);
        dchk_name_q.push_back(n);
        dchk_act_q.push_back(a);
        dchk_exp_q.push_back(e);
    endtask

    // Advance on negedges; fires the armed host collision in the bus_wr cycle
    task automatic tick(input int n);
        repeat (n) begin
            @(negedge CLK);
            if (coll_arm && bus_wr) begin
                host_we    = 1'b1;
                host_addr  = 4'd4;
                host_wdata = 8'hEE;
                coll_arm   = 1'b0;
                coll_hit   = 1'b1;
            end else begin
                host_we = 1'b0;
            end
            if (busy) busy_seen = 1'b1;
            if (!osda) low_seen = 1'b1;
        end
    endtask

    task automatic rd_reg(input logic [3:0] a, input logic [7:0] e, input string n);
        host_addr = a;
        #1;
        check(n, int'(host_rdata), int'(e));
    endtask

    task automatic host_wr(input logic [3:0] a, input logic [7:0] d);
        @(negedge CLK);
        host_addr  = a;
        host_wdata = d;
        host_we    = 1'b1;
        tick(1);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; tick(Q);
        scl   = 1'b1; tick(Q);
        sda_m = 1'b0; tick(Q);
        scl   = 1'b0; tick(Q);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; tick(Q);
        scl   = 1'b1; tick(Q);
        sda_m = 1'b1; tick(2 * Q);
    endtask

    task automatic wbit(input logic b);
        sda_m = b;    tick(Q);
        scl   = 1'b1; tick(2 * Q);
        scl   = 1'b0; tick(Q);
    endtask

    task automatic rbit(output logic b);
        sda_m = 1'b1; tick(Q);
        scl   = 1'b1; tick(Q);
        b = isda;     tick(Q);
        scl   = 1'b0; tick(Q);
    endtask

    task automatic wbyte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) wbit(d[i]);
        rbit(ack);
    endtask

    task automatic rbyte(output logic [7:0] d, input logic mack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            rbit(b);
            d[i] = b;
        end
        wbit(mack);
    endtask

    // Global bound so the run always terminates
    initial begin
        #2000000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic       ack;
        logic [7:0] d;
        int         glitch_ack_exp;

        tick(4);
        check("reset_osda", int'(osda), 1);
        check("reset_busy", int'(busy), 0);
        Reset = 1'b0;
        tick(4);
        check("reset_bus_wr", int'(bus_wr), 0);
        rd_reg(4'd0, 8'h00, "reset_reg0");
        rd_reg(4'd15, 8'h00, "reset_reg15");

        // Multi-byte write with auto-increment
        exp_waddr_q.push_back(3);
        exp_waddr_q.push_back(4);
        i2c_start();
        wbyte(8'h0A, ack); check("t1_addr_ack", int'(ack), 0);
        check("t1_busy_high", int'(busy), 1);
        wbyte(8'h03, ack); check("t1_reg_ack", int'(ack), 0);
        wbyte(8'h5A, ack); check("t1_d0_ack", int'(ack), 0);
        wbyte(8'hA5, ack); check("t1_d1_ack", int'(ack), 0);
        i2c_stop();
        check("t1_busy_low", int'(busy), 0);
        rd_reg(4'd3, 8'h5A, "t1_reg3");
        rd_reg(4'd4, 8'hA5, "t1_reg4");

        // Write across the wrap point, then combined read with repeated START
        exp_waddr_q.push_back(15);
        exp_waddr_q.push_back(0);
        i2c_start();
        wbyte(8'h0A, ack);
        wbyte(8'h0F, ack);
        wbyte(8'hC3, ack);
        wbyte(8'h3C, ack);
        i2c_stop();
        rd_reg(4'd15, 8'hC3, "t2_reg15");
        rd_reg(4'd0, 8'h3C, "t2_reg0_wrap");
        i2c_start();
        wbyte(8'h0A, ack); check("t2_addr_ack", int'(ack), 0);
        wbyte(8'h0F, ack); check("t2_reg_ack", int'(ack), 0);
        i2c_start();
        wbyte(8'h0B, ack); check("t2_raddr_ack", int'(ack), 0);
        rbyte(d, 1'b0);    check("t2_rd0", int'(d), 8'hC3);
        rbyte(d, 1'b1);    check("t2_rd1_wrap", int'(d), 8'h3C);
        tick(Q);
        check("t2_release_after_nack", int'(osda), 1);
        check("t2_busy_after_nack", int'(busy), 0);
        i2c_stop();

        // Address miss: no drive, never busy
        busy_seen = 1'b0;
        low_seen  = 1'b0;
        i2c_start();
        wbyte(8'h0C, ack); check("t3_addr_nack", int'(ack), 1);
        wbyte(8'h01, ack); check("t3_byte_nack", int'(ack), 1);
        i2c_stop();
        check("t3_busy_never", int'(busy_seen), 0);
        check("t3_osda_never_low", int'(low_seen), 0);
        rd_reg(4'd1, 8'h00, "t3_reg1");

        // Out-of-range register index
        i2c_start();
        wbyte(8'h0A, ack); check("t4_addr_ack", int'(ack), 0);
        wbyte(8'h20, ack); check("t4_reg_nack", int'(ack), 1);
        wbyte(8'h77, ack); check("t4_data_ignored", int'(ack), 1);
        i2c_stop();
        rd_reg(4'd0, 8'h3C, "t4_reg0_kept");
        i2c_start();
        wbyte(8'h0B, ack);
        rbyte(d, 1'b1);    check("t4_ptr_kept", int'(d), 8'h3C);
        i2c_stop();

        // Host write elsewhere, then a same-index collision
        host_wr(4'd7, 8'h42);
        rd_reg(4'd7, 8'h42, "t5_host_wr");
        exp_waddr_q.push_back(4);
        coll_hit = 1'b0;
        coll_arm = 1'b1;
        i2c_start();
        wbyte(8'h0A, ack);
        wbyte(8'h04, ack);
        wbyte(8'h99, ack);
        i2c_stop();
        coll_arm = 1'b0;
        check("t5_collision_hit", int'(coll_hit), 1);
        rd_reg(4'd4, 8'h99, "t5_bus_wins");

        // STOP after four data bits commits nothing
        i2c_start();
        wbyte(8'h0A, ack);
        wbyte(8'h08, ack); check("t5_reg8_ack", int'(ack), 0);
        for (int i = 0; i < 4; i++) wbit(1'b1);
        i2c_stop();
        rd_reg(4'd8, 8'h00, "t5_partial_dropped");

        // Reset while driving read data releases SDA at once
        i2c_start();
        wbyte(8'h0A, ack);
        wbyte(8'h03, ack);
        i2c_start();
        wbyte(8'h0B, ack);
        tick(Q);
        check("t5_rdata_drive_low", int'(osda), 0);
        Reset = 1'b1;
        #1;
        check("t5_reset_release", int'(osda), 1);
        tick(2);
        Reset = 1'b0;
        tick(2);
        check("t5_reset_busy", int'(busy), 0);
        rd_reg(4'd3, 8'h00, "t5_reset_reg3");
        rd_reg(4'd4, 8'h00, "t5_reset_reg4");
        scl = 1'b1;
        sda_m = 1'b1;
        tick(2 * Q);

        // One-CLK SDA spike while SCL is high, SCL falling as SDA recovers
`ifdef I2C_GLITCH_FILTER_EN
        glitch_ack_exp = 1;
`else
        glitch_ack_exp = 0;
`endif
        @(negedge CLK);
        sda_m = 1'b0;
        @(negedge CLK);
        sda_m = 1'b1;
        scl   = 1'b0;
        tick(Q);
        wbyte(8'h0A, ack); check("t6_glitch_start", int'(ack), glitch_ack_exp);
        i2c_stop();

        check("commits_all_seen", exp_waddr_q.size(), 0);
        tick(3);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
